// File: rtl/probe_capture_core.sv
// probe_capture_core: logic-analyser style capture engine.
// Samples a probe bus into a circular block RAM. The capture keeps a
// configurable number of samples from the trigger onward and fills the
// rest of the buffer with pre-trigger history. The buffer is read back
// oldest-first once the capture is complete.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   probe_data              sampled bus, one sample per clock
//   trig_value, trig_mask   trigger compare value; mask bit 1 = compared
//   trig_edge               0 = level match, 1 = transition into match
//   post_count              samples kept from the trigger onward (trigger included)
//   arm, abort              single-cycle start / cancel requests
//   busy, trig_seen, done   status flags
//   trig_index              read-order index of the trigger sample
//   rd_en, rd_addr          readback request; rd_addr 0 = oldest sample
//   rd_data, rd_valid       readback data, one cycle after the request
module probe_capture_core #(
    parameter int unsigned PROBE_W = 34,
    parameter int unsigned DEPTH   = 4096,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe_data,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic               trig_edge,
    input  logic [AW:0]        post_count,
    input  logic               arm,
    input  logic               abort,
    output logic               busy,
    output logic               trig_seen,
    output logic               done,
    output logic [AW-1:0]      trig_index,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [PROBE_W-1:0] rd_data,
    output logic               rd_valid
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PROBE_W-1:0]  s_q;
    logic                match_prev_q, match_prev_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       plen_q, plen_d;
    logic [CW-1:0]       pre_q, pre_d;
    logic                busy_d, trig_seen_d, done_d, rd_valid_d;
    logic [AW-1:0]       trig_index_d;

    logic                match_c;
    logic                fire_c;
    logic                wr_en_c;
    logic [CW-1:0]       plen_c;
    logic [CW-1:0]       pre_c;
    logic [AW-1:0]       rd_ptr_c;

    logic [PROBE_W-1:0]  mem [DEPTH];

    // Trigger compare on the registered sample
    always_comb begin
        match_c = ((s_q ^ trig_value) & trig_mask) == '0;
        fire_c  = match_c && (!trig_edge || !match_prev_q);
    end

    // Post-trigger length clamped to 1..DEPTH; the remainder is pre-trigger history
    always_comb begin
        if (post_count == '0) begin
            plen_c = ONE_C;
        end else if (post_count > DEPTH_V) begin
            plen_c = DEPTH_V;
        end else begin
            plen_c = post_count;
        end
        pre_c = DEPTH_V - plen_c;
    end

    // Readback is addressed relative to the frozen write pointer (oldest sample)
    always_comb begin
        rd_ptr_c = wr_ptr_q + rd_addr;
    end

    // Capture FSM: next state, counters and status flags
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        plen_d       = plen_q;
        pre_d        = pre_q;
        match_prev_d = match_prev_q;
        trig_seen_d  = trig_seen;
        trig_index_d = trig_index;
        wr_en_c      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    plen_d       = plen_c;
                    pre_d        = pre_c;
                    cnt_d        = '0;
                    wr_ptr_d     = '0;
                    trig_seen_d  = 1'b0;
                    match_prev_d = 1'b1;
                    trig_index_d = AW'(pre_c);
                    state_d      = (pre_c == '0) ? ST_WAIT : ST_PRE;
                end
            end
            ST_PRE: begin
                wr_en_c  = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (cnt_q == pre_q - ONE_C) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_WAIT: begin
                wr_en_c      = 1'b1;
                wr_ptr_d     = wr_ptr_q + AW'(1);
                match_prev_d = match_c;
                if (fire_c) begin
                    trig_seen_d = 1'b1;
                    cnt_d       = ONE_C;
                    state_d     = (plen_q == ONE_C) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                wr_en_c  = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (cnt_q == plen_q - ONE_C) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous arm
        if (abort) begin
            state_d      = ST_IDLE;
            trig_seen_d  = 1'b0;
            match_prev_d = 1'b1;
            wr_en_c      = 1'b0;
        end

        busy_d     = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
        done_d     = (state_d == ST_DONE);
        rd_valid_d = rd_en && (state_q == ST_DONE);
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            match_prev_q <= 1'b1;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            plen_q       <= ONE_C;
            pre_q        <= '0;
            busy         <= 1'b0;
            trig_seen    <= 1'b0;
            done         <= 1'b0;
            trig_index   <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= probe_data;
            match_prev_q <= match_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            plen_q       <= plen_d;
            pre_q        <= pre_d;
            busy         <= busy_d;
            trig_seen    <= trig_seen_d;
            done         <= done_d;
            trig_index   <= trig_index_d;
            rd_valid     <= rd_valid_d;
        end
    end

    // Simple dual-port sample RAM with registered read; never reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= s_q;
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr_c];
        end
    end

endmodule

// File: tb/tb_probe_capture_core.sv
// Randomised and directed bench for probe_capture_core (PROBE_W=8, DEPTH=16).
// The reference model works on the stream of samples written after arm:
// it finds the trigger position from the compare rules, derives the
// flag timing and the final buffer contents arithmetically.
module tb_probe_capture_core;

    localparam int unsigned PW = 8;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] probe_data;
    logic [PW-1:0] trig_value;
    logic [PW-1:0] trig_mask;
    logic          trig_edge;
    logic [AW:0]   post_count;
    logic          arm;
    logic          abort;
    logic          busy;
    logic          trig_seen;
    logic          done;
    logic [AW-1:0] trig_index;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data;
    logic          rd_valid;

    logic [7:0] p [256];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    probe_capture_core #(.PROBE_W(PW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .probe_data (probe_data),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .trig_edge  (trig_edge),
        .post_count (post_count),
        .arm        (arm),
        .abort      (abort),
        .busy       (busy),
        .trig_seen  (trig_seen),
        .done       (done),
        .trig_index (trig_index),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_match(input logic [7:0] d, input logic [7:0] m, input logic [7:0] v);
        return ((d ^ v) & m) == 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) p[k] = 8'($urandom);
    endtask

    // Arm with the current p[] as the sample stream, track flags, then read back
    task automatic run_capture(input string tag, input logic [7:0] m, input logic [7:0] v,
                               input logic e, input int pc);
        int plen, pre, f, last, seen_at, done_at;
        plen = (pc == 0) ? 1 : ((pc > int'(DP)) ? int'(DP) : pc);
        pre  = int'(DP) - plen;
        f    = -1;
        for (int k = pre; k < 200 && f < 0; k++) begin
            if (is_match(p[8'(k)], m, v) &&
                (!e || (k > pre && !is_match(p[8'(k - 1)], m, v))))
                f = k;
        end
        if (f < 0) f = 1000;
        last = f + plen - 1;

        trig_mask  = m;
        trig_value = v;
        trig_edge  = e;
        post_count = 5'(pc);
        probe_data = p[0];
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        seen_at = -1;
        done_at = -1;
        for (int j = 0; j < 240; j++) begin
            if (j == 0) check_eq({tag, " busy_after_arm"}, 32'(busy), 32'd1);
            if (trig_seen && seen_at < 0) seen_at = j;
            if (done && done_at < 0) done_at = j;
            if (done_at >= 0) break;
            probe_data = p[8'(j + 1)];
            tick();
        end
        check_eq({tag, " trig_seen_cycle"}, 32'(seen_at), 32'(f + 1));
        check_eq({tag, " done_cycle"}, 32'(done_at), 32'(last + 1));
        check_eq({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check_eq({tag, " trig_index"}, 32'(trig_index), 32'((int'(DP) - plen) % int'(DP)));
        if (done_at >= 0) begin
            for (int a = 0; a < int'(DP); a++) begin
                rd_en   = 1'b1;
                rd_addr = 4'(a);
                probe_data = 8'($urandom);
                tick();
                check_eq({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
                check_eq({tag, $sformatf(" rd_data[%0d]", a)}, 32'(rd_data),
                         32'(p[8'(last - int'(DP) + 1 + a)]));
            end
            rd_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m, v, lowbit;
        int pc, k, n;
        logic e;

        rst_n = 1'b0; probe_data = '0; trig_value = '0; trig_mask = '0; trig_edge = 1'b0;
        post_count = '0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset trig_seen", 32'(trig_seen), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset rd_valid", 32'(rd_valid), 32'd0);
        check_eq("reset trig_index", 32'(trig_index), 32'd0);
        rst_n = 1'b1;
        tick();

        // Level trigger on a ramp
        for (int i = 0; i < 256; i++) p[i] = 8'(i);
        run_capture("level_ramp", 8'hFF, 8'h20, 1'b0, 4);

        // Edge trigger: needs a non-matching sample before the match
        for (int i = 0; i < 256; i++) p[i] = 8'h01;
        p[20] = 8'h00;
        run_capture("edge", 8'h01, 8'h01, 1'b1, 4);

        // Full-depth post and zero post (treated as one)
        fill_random();
        run_capture("post16", 8'h00, 8'h5A, 1'b0, 16);
        fill_random();
        run_capture("post0", 8'h00, 8'h5A, 1'b0, 0);

        // Rearm from DONE with an all-zero mask
        fill_random();
        run_capture("rearm_mask0", 8'h00, 8'($urandom), 1'b0, 5);

        // Abort together with arm while waiting for a trigger
        for (int i = 0; i < 256; i++) p[i] = 8'h00;
        trig_mask = 8'hFF; trig_value = 8'hAA; trig_edge = 1'b0; post_count = 5'd4;
        probe_data = 8'h00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (15) tick();
        check_eq("abort pre busy", 32'(busy), 32'd1);
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        check_eq("abort trig_seen", 32'(trig_seen), 32'd0);
        repeat (3) tick();
        check_eq("abort stays idle", 32'(busy), 32'd0);
        fill_random();
        run_capture("after_abort", 8'h00, 8'h00, 1'b0, 7);

        // Asynchronous reset in the middle of the post-trigger phase
        trig_mask = 8'hFF; trig_value = 8'h20; trig_edge = 1'b0; post_count = 5'd8;
        probe_data = 8'h00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n = 0;
        for (int j = 1; j < 100; j++) begin
            probe_data = 8'(j);
            tick();
            if (trig_seen && !done) begin
                n = 1;
                break;
            end
        end
        check_eq("reset_mid reached_post", 32'(n), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid busy", 32'(busy), 32'd0);
        check_eq("reset_mid trig_seen", 32'(trig_seen), 32'd0);
        check_eq("reset_mid done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        check_eq("idle rd_valid", 32'(rd_valid), 32'd0);
        check_eq("idle busy", 32'(busy), 32'd0);

        // Randomised captures with a guaranteed trigger opportunity
        for (int t = 0; t < 10; t++) begin
            fill_random();
            pc = $urandom_range(0, 20);
            e  = 1'($urandom_range(0, 1));
            m  = 8'($urandom);
            if (m == 8'h00) m = 8'h80;
            v  = 8'($urandom);
            k  = (int'(DP) - ((pc == 0) ? 1 : ((pc > 16) ? 16 : pc))) + $urandom_range(1, 20);
            p[8'(k)] = (8'($urandom) & ~m) | (v & m);
            lowbit = m & (~m + 8'd1);
            if (e) p[8'(k - 1)] = p[8'(k)] ^ lowbit;
            run_capture($sformatf("rand%0d", t), m, v, e, pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
